// File: rtl/ascon_sbox_ti_serial.sv
// 3-share threshold-implementation Ascon S-box layer, SLICE_W bit-columns per cycle.
// Optional: define ASCON_TI_REMASK_EN to refresh every result slice with rnd.
module ascon_sbox_ti_serial #(
  parameter int SLICE_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [319:0]          s0_in,
  input  logic [319:0]          s1_in,
  input  logic [319:0]          s2_in,
  input  logic [10*SLICE_W-1:0] rnd,
  output logic                  busy,
  output logic                  done,
  output logic [319:0]          s0_out,
  output logic [319:0]          s1_out,
  output logic [319:0]          s2_out
);

  localparam int NSLICE = 64 / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [2:0][319:0]            w_q, w_d;
  logic [2:0][319:0]            r_q, r_d;
  logic [2:0][4:0][SLICE_W-1:0] xs, a, c, y;
  logic                         accept;

  function automatic logic [63:0] rotr(input logic [63:0] v);
    logic [127:0] t;
    t = {v, v} >> SLICE_W;
    return t[63:0];
  endfunction

  function automatic logic [63:0] shin(input logic [63:0] v, input logic [SLICE_W-1:0] n);
    logic [SLICE_W+63:0] t;
    t = {n, v} >> SLICE_W;
    return t[63:0];
  endfunction

  // Affine layers are linear, so they run share-locally; only chi mixes shares.
  // Output share j reads input shares j+1 and j+2 only (non-completeness).
  always_comb begin
    xs = '0;
    a  = '0;
    c  = '0;
    y  = '0;
    for (int s = 0; s < 3; s++) begin
      for (int l = 0; l < 5; l++) xs[s][l] = w_q[s][(4-l)*64 +: SLICE_W];
      a[s][0] = xs[s][0] ^ xs[s][4];
      a[s][1] = xs[s][1];
      a[s][2] = xs[s][2] ^ xs[s][1];
      a[s][3] = xs[s][3];
      a[s][4] = xs[s][4] ^ xs[s][3];
    end
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 5; i++) begin
        c[j][i] = a[(j+1)%3][i] ^ a[(j+1)%3][(i+2)%5]
                ^ (a[(j+1)%3][(i+1)%5] & a[(j+1)%3][(i+2)%5])
                ^ (a[(j+1)%3][(i+1)%5] & a[(j+2)%3][(i+2)%5])
                ^ (a[(j+2)%3][(i+1)%5] & a[(j+1)%3][(i+2)%5]);
      end
      y[j][0] = c[j][0] ^ c[j][4];
      y[j][1] = c[j][1] ^ c[j][0];
      y[j][2] = c[j][2];
      y[j][3] = c[j][3] ^ c[j][2];
      y[j][4] = c[j][4];
    end
    y[2][2] = ~y[2][2];
`ifdef ASCON_TI_REMASK_EN
    for (int l = 0; l < 5; l++) begin
      y[0][l] = y[0][l] ^ rnd[5*SLICE_W + (4-l)*SLICE_W +: SLICE_W];
      y[1][l] = y[1][l] ^ rnd[(4-l)*SLICE_W +: SLICE_W];
      y[2][l] = y[2][l] ^ rnd[5*SLICE_W + (4-l)*SLICE_W +: SLICE_W]
                        ^ rnd[(4-l)*SLICE_W +: SLICE_W];
    end
`endif
  end

`ifndef ASCON_TI_REMASK_EN
  logic unused_rnd;
  assign unused_rnd = ^rnd;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    r_d     = r_q;
    accept  = start && (state_q == IDLE || state_q == DONE);
    unique case (state_q)
      IDLE: ;
      RUN: begin
        for (int s = 0; s < 3; s++) begin
          for (int l = 0; l < 5; l++) begin
            w_d[s][(4-l)*64 +: 64] = rotr(w_q[s][(4-l)*64 +: 64]);
            r_d[s][(4-l)*64 +: 64] = shin(r_q[s][(4-l)*64 +: 64], y[s][l]);
          end
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      w_d     = {s2_in, s1_in, s0_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      r_q     <= r_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign s0_out = r_q[0];
  assign s1_out = r_q[1];
  assign s2_out = r_q[2];

endmodule
